// File: rtl/rename_commit_ctrl_pkg.sv
// Shared constants, commit FSM encoding and occupancy arithmetic for the
// rename commit controller.
package rename_commit_ctrl_pkg;

  localparam int RRF_SEL = 6;
  localparam int REG_SEL = 5;
  localparam int CNT_W   = 32;
  localparam int OCC_W   = RRF_SEL + 1;

  typedef enum logic [1:0] {
    CMT_RUN   = 2'd0,
    CMT_DRAIN = 2'd1,
    CMT_DONE  = 2'd2
  } cmt_state_e;

  // In-flight count after this cycle's allocations and retirements.
  function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ,
                                                input logic [1:0]       acc,
                                                input logic [1:0]       ret);
    return occ + {{(OCC_W-2){1'b0}}, acc} - {{(OCC_W-2){1'b0}}, ret};
  endfunction

endpackage

// File: rtl/rename_commit_pick.sv
// Selects how many ROB head entries retire this cycle and which one owns the
// single ARF/RRF commit write port.
module rename_commit_pick
  import rename_commit_ctrl_pkg::*;
(
  input  logic               v0_i,
  input  logic               v1_i,
  input  logic [1:0]         fin_i,
  input  logic [1:0]         dst_en_i,
  input  logic [REG_SEL-1:0] dstnum0_i,
  input  logic [REG_SEL-1:0] dstnum1_i,
  input  logic [RRF_SEL-1:0] comptr_i,
  output logic [1:0]         n_o,
  output logic               we_o,
  output logic [REG_SEL-1:0] dstnum_o,
  output logic [RRF_SEL-1:0] tag_o
);

  logic c0_s;
  logic c1_s;

  // Retire in order; a second retire is blocked when both entries need the write port.
  always_comb begin
    c0_s     = v0_i & fin_i[0];
    c1_s     = c0_s & v1_i & fin_i[1] & ~(dst_en_i[0] & dst_en_i[1]);
    n_o      = {1'b0, c0_s} + {1'b0, c1_s};
    we_o     = (c0_s & dst_en_i[0]) | (c1_s & dst_en_i[1]);
    dstnum_o = {REG_SEL{1'b0}};
    tag_o    = {RRF_SEL{1'b0}};
    if (c0_s & dst_en_i[0]) begin
      dstnum_o = dstnum0_i;
      tag_o    = comptr_i;
    end else if (c1_s & dst_en_i[1]) begin
      dstnum_o = dstnum1_i;
      tag_o    = comptr_i + {{(RRF_SEL-1){1'b0}}, 1'b1};
    end else begin
      dstnum_o = {REG_SEL{1'b0}};
      tag_o    = {RRF_SEL{1'b0}};
    end
  end

endmodule

// File: rtl/rename_commit_ctrl.sv
// Commit-side controller: retires up to two ROB head entries per cycle, tracks
// RRF occupancy and the commit pointer, and drains the pipeline on request.
module rename_commit_ctrl
  import rename_commit_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         dp_alloc_num_i,
  input  logic               rrf_allocatable_i,
  input  logic [1:0]         rob_fin_i,
  input  logic [1:0]         rob_dst_en_i,
  input  logic [REG_SEL-1:0] rob_dstnum0_i,
  input  logic [REG_SEL-1:0] rob_dstnum1_i,
  input  logic               drain_req_i,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic [1:0]         com_inst_num_o,
  output logic               completed_we_o,
  output logic [REG_SEL-1:0] completed_dstnum_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
  output logic               stall_dp_o,
  output logic [OCC_W-1:0]   occupancy_o,
  output logic               drain_done_o,
  output logic [CNT_W-1:0]   commit_cnt_o
);

  cmt_state_e         state_q, state_d;
  logic [RRF_SEL-1:0] comptr_q, comptr_d;
  logic [OCC_W-1:0]   occupancy_q, occupancy_d;
  logic [CNT_W-1:0]   commit_cnt_q, commit_cnt_d;
  logic [1:0]         com_inst_num_q;
  logic               completed_we_q;
  logic [REG_SEL-1:0] completed_dstnum_q;
  logic [RRF_SEL-1:0] completed_tag_q;

  logic               v0_s, v1_s, stall_s;
  logic [1:0]         acc_s, pick_n_s;
  logic               pick_we_s;
  logic [REG_SEL-1:0] pick_dstnum_s;
  logic [RRF_SEL-1:0] pick_tag_s;

  rename_commit_pick u_pick (
    .v0_i      (v0_s),
    .v1_i      (v1_s),
    .fin_i     (rob_fin_i),
    .dst_en_i  (rob_dst_en_i),
    .dstnum0_i (rob_dstnum0_i),
    .dstnum1_i (rob_dstnum1_i),
    .comptr_i  (comptr_q),
    .n_o       (pick_n_s),
    .we_o      (pick_we_s),
    .dstnum_o  (pick_dstnum_s),
    .tag_o     (pick_tag_s)
  );

  // Head validity, dispatch acceptance, counter updates and drain FSM next state.
  always_comb begin
    v0_s         = (occupancy_q != {OCC_W{1'b0}});
    v1_s         = (occupancy_q >= {{(OCC_W-2){1'b0}}, 2'd2});
    stall_s      = ~reset_i | (state_q != CMT_RUN) | ~rrf_allocatable_i;
    acc_s        = stall_s ? 2'd0 : dp_alloc_num_i;
    occupancy_d  = occ_next(occupancy_q, acc_s, pick_n_s);
    comptr_d     = comptr_q + {{(RRF_SEL-2){1'b0}}, pick_n_s};
    commit_cnt_d = commit_cnt_q + {{(CNT_W-2){1'b0}}, pick_n_s};
    state_d      = state_q;
    case (state_q)
      CMT_RUN: begin
        if (drain_req_i) state_d = CMT_DRAIN;
        else             state_d = CMT_RUN;
      end
      CMT_DRAIN: begin
        if (!drain_req_i)                          state_d = CMT_RUN;
        else if (occupancy_d == {OCC_W{1'b0}})     state_d = CMT_DONE;
        else                                       state_d = CMT_DRAIN;
      end
      CMT_DONE: begin
        if (!drain_req_i) state_d = CMT_RUN;
        else              state_d = CMT_DONE;
      end
      default: state_d = CMT_RUN;
    endcase
  end

  // State and registered commit-port outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q            <= CMT_RUN;
      comptr_q           <= {RRF_SEL{1'b0}};
      occupancy_q        <= {OCC_W{1'b0}};
      commit_cnt_q       <= {CNT_W{1'b0}};
      com_inst_num_q     <= 2'd0;
      completed_we_q     <= 1'b0;
      completed_dstnum_q <= {REG_SEL{1'b0}};
      completed_tag_q    <= {RRF_SEL{1'b0}};
    end else begin
      state_q            <= state_d;
      comptr_q           <= comptr_d;
      occupancy_q        <= occupancy_d;
      commit_cnt_q       <= commit_cnt_d;
      com_inst_num_q     <= pick_n_s;
      completed_we_q     <= pick_we_s;
      completed_dstnum_q <= pick_dstnum_s;
      completed_tag_q    <= pick_tag_s;
    end
  end

  assign comptr_o               = comptr_q;
  assign com_inst_num_o         = com_inst_num_q;
  assign completed_we_o         = completed_we_q;
  assign completed_dstnum_o     = completed_dstnum_q;
  assign completed_dst_rrftag_o = completed_tag_q;
  assign stall_dp_o             = stall_s;
  assign occupancy_o            = occupancy_q;
  assign drain_done_o           = (state_q == CMT_DONE);
  assign commit_cnt_o           = commit_cnt_q;

endmodule

// File: tb/tb_rename_commit_ctrl.sv
// Self-checking bench for rename_commit_ctrl: directed scenarios plus random
// traffic against a behavioural in-order retirement model.
module tb_rename_commit_ctrl;

  localparam int ENTRIES = 64;
  localparam int S_RUN = 0, S_DRAIN = 1, S_DONE = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  dp_alloc_num = 2'd0;
  logic        rrf_alloc = 1'b1;
  logic [1:0]  rob_fin = 2'd0;
  logic [1:0]  rob_dst_en = 2'd0;
  logic [4:0]  dstnum0 = 5'd0, dstnum1 = 5'd0;
  logic        drain_req = 1'b0;

  logic [5:0]  comptr;
  logic [1:0]  com_num;
  logic        com_we;
  logic [4:0]  com_dst;
  logic [5:0]  com_tag;
  logic        stall;
  logic [6:0]  occ;
  logic        drain_done;
  logic [31:0] cnt;

  int total = 0, bad = 0;

  // Model: head pointer, in-flight count, retired count, drain mode, last commit.
  int          m_ptr, m_occ, m_state, e_com, e_dst, e_tag;
  bit          e_we;
  logic [31:0] m_cnt;

  rename_commit_ctrl dut (
    .clk_i                  (clk),
    .reset_i                (reset_n),
    .dp_alloc_num_i         (dp_alloc_num),
    .rrf_allocatable_i      (rrf_alloc),
    .rob_fin_i              (rob_fin),
    .rob_dst_en_i           (rob_dst_en),
    .rob_dstnum0_i          (dstnum0),
    .rob_dstnum1_i          (dstnum1),
    .drain_req_i            (drain_req),
    .comptr_o               (comptr),
    .com_inst_num_o         (com_num),
    .completed_we_o         (com_we),
    .completed_dstnum_o     (com_dst),
    .completed_dst_rrftag_o (com_tag),
    .stall_dp_o             (stall),
    .occupancy_o            (occ),
    .drain_done_o           (drain_done),
    .commit_cnt_o           (cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 0; m_occ = 0; m_state = S_RUN; m_cnt = 32'd0;
    e_com = 0; e_we = 1'b0; e_dst = 0; e_tag = 0;
  endtask

  task automatic idle_inputs();
    dp_alloc_num = 2'd0; rrf_alloc = 1'b1; rob_fin = 2'd0; rob_dst_en = 2'd0;
    dstnum0 = 5'd0; dstnum1 = 5'd0; drain_req = 1'b0;
  endtask

  // One clock: predict next state from the retirement rules, then advance.
  task automatic tick();
    bit r0, r1, w0, w1, blocked;
    int n, acc, nocc, nstate, ndst, ntag;
    r0 = (m_occ >= 1) && rob_fin[0];
    r1 = r0 && (m_occ >= 2) && rob_fin[1] && !(rob_dst_en[0] && rob_dst_en[1]);
    n  = int'(r0) + int'(r1);
    w0 = r0 && rob_dst_en[0];
    w1 = r1 && rob_dst_en[1];
    ndst = 0; ntag = 0;
    if (w0) begin ndst = dstnum0; ntag = m_ptr; end
    else if (w1) begin ndst = dstnum1; ntag = (m_ptr + 1) % ENTRIES; end
    blocked = (m_state != S_RUN) || !rrf_alloc;
    acc  = blocked ? 0 : int'(dp_alloc_num);
    nocc = m_occ + acc - n;
    assert (nocc >= 0 && nocc <= ENTRIES) else $error("occupancy protocol violation %0d", nocc);
    nstate = m_state;
    if (m_state == S_RUN) nstate = drain_req ? S_DRAIN : S_RUN;
    else if (!drain_req) nstate = S_RUN;
    else if (m_state == S_DRAIN && nocc == 0) nstate = S_DONE;
    @(posedge clk); #1;
    m_ptr = (m_ptr + n) % ENTRIES; m_occ = nocc; m_cnt = m_cnt + 32'(n);
    m_state = nstate; e_com = n; e_we = w0 || w1; e_dst = ndst; e_tag = ntag;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%0b want=1", stall); end
    total++; if ({comptr, com_num, com_we, com_dst, com_tag, occ, drain_done, cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs ptr=%0d num=%0d we=%0b dst=%0d tag=%0d occ=%0d dd=%0b cnt=%0d want all 0",
                      comptr, com_num, com_we, com_dst, com_tag, occ, drain_done, cnt); end
    reset_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_release_stall got=%0b want=0", stall); end
  endtask

  task automatic test_dispatch();
    apply_reset();
    dp_alloc_num = 2'd2;
    repeat (3) tick();
    dp_alloc_num = 2'd0;
    total++; if (occ !== 7'd6) begin bad++; $display("FAIL dispatch_occ got=%0d want=6", occ); end
    total++; if (comptr !== 6'd0) begin bad++; $display("FAIL dispatch_ptr got=%0d want=0", comptr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dispatch_stall got=%0b want=0", stall); end
    total++; if (com_num !== 2'd0) begin bad++; $display("FAIL dispatch_com got=%0d want=0", com_num); end
  endtask

  task automatic test_dual_retire();
    apply_reset();
    dp_alloc_num = 2'd2;
    repeat (2) tick();
    dp_alloc_num = 2'd0; rob_fin = 2'b11; rob_dst_en = 2'b01; dstnum0 = 5'd5; dstnum1 = 5'd9;
    tick();
    total++; if ({com_num, com_we, com_dst, com_tag} !== {2'd2, 1'b1, 5'd5, 6'd0}) begin
      bad++; $display("FAIL dual_commit num=%0d we=%0b dst=%0d tag=%0d want 2/1/5/0", com_num, com_we, com_dst, com_tag); end
    total++; if (comptr !== 6'd2) begin bad++; $display("FAIL dual_ptr got=%0d want=2", comptr); end
    total++; if (occ !== 7'd2) begin bad++; $display("FAIL dual_occ got=%0d want=2", occ); end
  endtask

  task automatic test_port_conflict();
    apply_reset();
    dp_alloc_num = 2'd2;
    tick();
    dp_alloc_num = 2'd0; rob_fin = 2'b11; rob_dst_en = 2'b11; dstnum0 = 5'd3; dstnum1 = 5'd4;
    tick();
    total++; if ({com_num, com_we, com_dst, com_tag} !== {2'd1, 1'b1, 5'd3, 6'd0}) begin
      bad++; $display("FAIL conflict_first num=%0d we=%0b dst=%0d tag=%0d want 1/1/3/0", com_num, com_we, com_dst, com_tag); end
    dstnum0 = 5'd4;
    tick();
    total++; if ({com_num, com_we, com_dst, com_tag} !== {2'd1, 1'b1, 5'd4, 6'd1}) begin
      bad++; $display("FAIL conflict_second num=%0d we=%0b dst=%0d tag=%0d want 1/1/4/1", com_num, com_we, com_dst, com_tag); end
    total++; if (occ !== 7'd0) begin bad++; $display("FAIL conflict_occ got=%0d want=0", occ); end
  endtask

  task automatic test_wrap();
    int d, left;
    apply_reset();
    for (int i = 0; i < 100 && !(m_ptr == 63 && m_occ == 2); i++) begin
      d = 65 - (m_ptr + m_occ);
      dp_alloc_num = (d >= 2) ? 2'd2 : 2'(d);
      left = 63 - m_ptr;
      rob_fin = (left >= 2) ? 2'b11 : ((left == 1) ? 2'b01 : 2'b00);
      rob_dst_en = 2'b00;
      tick();
    end
    total++; if (comptr !== 6'd63 || occ !== 7'd2) begin
      bad++; $display("FAIL wrap_setup ptr=%0d occ=%0d want 63/2", comptr, occ); end
    dp_alloc_num = 2'd0; rob_fin = 2'b11; rob_dst_en = 2'b10; dstnum0 = 5'd1; dstnum1 = 5'd7;
    tick();
    total++; if ({com_num, com_we, com_dst, com_tag} !== {2'd2, 1'b1, 5'd7, 6'd0}) begin
      bad++; $display("FAIL wrap_commit num=%0d we=%0b dst=%0d tag=%0d want 2/1/7/0", com_num, com_we, com_dst, com_tag); end
    total++; if (comptr !== 6'd1) begin bad++; $display("FAIL wrap_ptr got=%0d want=1", comptr); end
    total++; if (cnt !== 32'd65) begin bad++; $display("FAIL wrap_cnt got=%0d want=65", cnt); end
  endtask

  task automatic test_drain();
    apply_reset();
    dp_alloc_num = 2'd2; tick();
    dp_alloc_num = 2'd1; tick();
    dp_alloc_num = 2'd0; drain_req = 1'b1; rob_fin = 2'b01;
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL drain_stall got=%0b want=1", stall); end
    dp_alloc_num = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (occ !== 7'(m_occ) || drain_done !== (m_state == S_DONE)) begin
        bad++; $display("FAIL drain_step%0d occ=%0d dd=%0b want %0d/%0b", i, occ, drain_done, m_occ, m_state == S_DONE); end
    end
    total++; if (drain_done !== 1'b1 || occ !== 7'd0) begin
      bad++; $display("FAIL drain_done dd=%0b occ=%0d want 1/0", drain_done, occ); end
    drain_req = 1'b0;
    tick();
    total++; if (stall !== 1'b0 || drain_done !== 1'b0 || occ !== 7'd0) begin
      bad++; $display("FAIL drain_exit stall=%0b dd=%0b occ=%0d want 0/0/0", stall, drain_done, occ); end
  endtask

  task automatic test_drain_empty();
    apply_reset();
    drain_req = 1'b1;
    tick();
    total++; if (drain_done !== 1'b0 || stall !== 1'b1) begin
      bad++; $display("FAIL empty_drain_c1 dd=%0b stall=%0b want 0/1", drain_done, stall); end
    tick();
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL empty_drain_c2 dd=%0b want 1", drain_done); end
    drain_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    dp_alloc_num = 2'd2;
    repeat (2) tick();
    dp_alloc_num = 2'd0; drain_req = 1'b1; rob_fin = 2'b11; rob_dst_en = 2'b00;
    tick();
    rob_fin = 2'b00;
    tick();
    total++; if (occ !== 7'd2 || drain_done !== 1'b0 || cnt !== 32'd2) begin
      bad++; $display("FAIL middrain_setup occ=%0d dd=%0b cnt=%0d want 2/0/2", occ, drain_done, cnt); end
    #3 reset_n = 1'b0;
    #1;
    total++; if ({comptr, com_num, com_we, com_dst, com_tag, occ, drain_done, cnt} !== '0 || stall !== 1'b1) begin
      bad++; $display("FAIL middrain_async ptr=%0d num=%0d occ=%0d cnt=%0d stall=%0b want zeros and stall 1",
                      comptr, com_num, occ, cnt, stall); end
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || drain_done !== 1'b0) begin
      bad++; $display("FAIL middrain_run stall=%0b dd=%0b want 0/0", stall, drain_done); end
    dp_alloc_num = 2'd1; tick();
    dp_alloc_num = 2'd0; rob_fin = 2'b01; tick();
    total++; if (cnt !== 32'd1) begin bad++; $display("FAIL middrain_cnt got=%0d want=1", cnt); end
  endtask

  task automatic test_random();
    int d;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      d = $urandom_range(0, 2);
      if (m_occ + d > ENTRIES) d = ENTRIES - m_occ;
      dp_alloc_num = 2'(d);
      rrf_alloc    = ($urandom_range(0, 7) != 0);
      rob_fin      = 2'($urandom_range(0, 3));
      rob_dst_en   = 2'($urandom_range(0, 3));
      dstnum0      = 5'($urandom_range(0, 31));
      dstnum1      = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
      #1;
      total++; if (stall !== ((m_state != S_RUN) || !rrf_alloc)) begin
        bad++; $display("FAIL rand_stall it=%0d got=%0b", i, stall); end
      tick();
      total++; if (com_num !== 2'(e_com) || com_we !== e_we || com_dst !== 5'(e_dst) || com_tag !== 6'(e_tag)) begin
        bad++; $display("FAIL rand_commit it=%0d num=%0d we=%0b dst=%0d tag=%0d want %0d/%0b/%0d/%0d",
                        i, com_num, com_we, com_dst, com_tag, e_com, e_we, e_dst, e_tag); end
      total++; if (comptr !== 6'(m_ptr) || occ !== 7'(m_occ) || cnt !== m_cnt || drain_done !== (m_state == S_DONE)) begin
        bad++; $display("FAIL rand_state it=%0d ptr=%0d occ=%0d cnt=%0d dd=%0b want %0d/%0d/%0d/%0b",
                        i, comptr, occ, cnt, drain_done, m_ptr, m_occ, m_cnt, m_state == S_DONE); end
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_dual_retire();
    test_port_conflict();
    test_wrap();
    test_drain();
    test_drain_empty();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
